mem_arbiter: RTL and testbench

- Arbitrates one shared single-port unified memory between the fetch stage (instruction read) and the memory stage (data read/write, including push/pop).
- Sequences each multi-cycle memory access through a small FSM and returns the read data to the winning requester.
- Generates the stall signals that freeze the fetch stage and the downstream pipeline buffers while a requester waits.
- Sits between Fetch / the EM-stage memory logic and the memory array, all on the same clock.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared-memory arbiter and the memory array.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_fetch;
  logic              stall_pipe;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, stall_pipe
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, stall_pipe
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter: data beats fetch except after DATA_MAX consecutive data
// grants with fetch waiting; each access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE.
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 2,
  parameter int DATA_MAX = 4
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int LAT_W    = $clog2(MEM_LAT + 1);
  localparam int STREAK_W = $clog2(DATA_MAX + 1);
  localparam logic [LAT_W-1:0]    LAT_INIT    = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0]    LAT_ZERO    = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]    LAT_ONE     = LAT_W'(1);
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(DATA_MAX);
  localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
  localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STREAK_W-1:0] data_streak_q, data_streak_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

  logic                fetch_wins_s;
  logic [STREAK_W-1:0] streak_inc_s;

  // Fetch takes the slot when data is absent or has used up its consecutive-grant allowance.
  assign fetch_wins_s = bus.if_req & (~bus.dm_req | (data_streak_q == STREAK_MAX));
  assign streak_inc_s = (data_streak_q == STREAK_MAX) ? STREAK_MAX : (data_streak_q + STREAK_ONE);

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    lat_cnt_d     = lat_cnt_q;
    data_streak_d = data_streak_q;
    mem_en_d      = mem_en_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_ready_d    = 1'b0;
    dm_ready_d    = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          state_d   = ST_ACCESS;
          mem_en_d  = 1'b1;
          lat_cnt_d = LAT_INIT;
          if (fetch_wins_s) begin
            owner_d       = OWN_FETCH;
            mem_we_d      = 1'b0;
            mem_addr_d    = bus.if_addr;
            mem_wdata_d   = {DATA_W{1'b0}};
            data_streak_d = STREAK_ZERO;
          end else begin
            owner_d       = OWN_DATA;
            mem_we_d      = bus.dm_we;
            mem_addr_d    = bus.dm_addr;
            mem_wdata_d   = bus.dm_wdata;
            data_streak_d = bus.if_req ? streak_inc_s : STREAK_ZERO;
          end
        end else begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (lat_cnt_q != LAT_ZERO) begin
          lat_cnt_d = lat_cnt_q - LAT_ONE;
        end else begin
          // Last access cycle: mem_rdata is valid now and only now.
          if (!mem_we_q) begin
            if (owner_q == OWN_FETCH) begin
              if_rdata_d = bus.mem_rdata;
            end else begin
              dm_rdata_d = bus.mem_rdata;
            end
          end else begin
            if_rdata_d = if_rdata_q;
          end
          if (owner_q == OWN_FETCH) begin
            if_ready_d = 1'b1;
          end else begin
            dm_ready_d = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_FETCH;
      lat_cnt_q     <= LAT_ZERO;
      data_streak_q <= STREAK_ZERO;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_wdata_q   <= {DATA_W{1'b0}};
      if_ready_q    <= 1'b0;
      dm_ready_q    <= 1'b0;
      if_rdata_q    <= {DATA_W{1'b0}};
      dm_rdata_q    <= {DATA_W{1'b0}};
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      lat_cnt_q     <= lat_cnt_d;
      data_streak_q <= data_streak_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_ready_q    <= if_ready_d;
      dm_ready_q    <= dm_ready_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
    end
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_ready    = if_ready_q;
  assign bus.dm_ready    = dm_ready_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.stall_fetch = bus.if_req & ~if_ready_q;
  assign bus.stall_pipe  = bus.dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic,
// all continuously compared against a transaction-timing model of the arbiter.
module tb_mem_arbiter;
  localparam int MEM_LAT  = 2;
  localparam int DATA_MAX = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .DATA_MAX(DATA_MAX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [9:0] a);
    if (a == 10'h010)      return 16'hA5A5;
    else if (a == 10'h200) return 16'h0F0F;
    else                   return {6'h2B, a} ^ 16'h5A5A;
  endfunction

  // Memory array: data only valid in the last access cycle, garbage otherwise.
  bit [15:0] mem [1024];
  bit        mem_wr [1024];
  int        en_cnt = 0;
  assign bus.mem_rdata = (bus.mem_en && en_cnt == MEM_LAT - 1) ?
                         (mem_wr[bus.mem_addr[9:0]] ? mem[bus.mem_addr[9:0]] : init_val(bus.mem_addr[9:0])) :
                         16'hDEAD;
  always @(posedge clk) begin
    if (reset && bus.mem_en && bus.mem_we && en_cnt == MEM_LAT - 1) begin
      mem[bus.mem_addr[9:0]]    <= bus.mem_wdata;
      mem_wr[bus.mem_addr[9:0]] <= 1'b1;
    end
    en_cnt <= (!reset || !bus.mem_en) ? 0 : en_cnt + 1;
  end

  // Reference model: one transaction in flight, timed by cycles elapsed since its grant.
  bit [15:0] sh_mem [1024];
  bit        sh_wr  [1024];
  bit        model_valid = 1'b0;
  bit        m_busy, m_own, m_we, take_fetch;
  int        m_t, m_streak;
  bit [15:0] m_addr, m_wdata, e_if_rdata, e_dm_rdata;
  bit        e_if_ready, e_dm_ready;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy = 0; m_t = 0; m_streak = 0; m_own = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      e_if_ready = 0; e_dm_ready = 0; e_if_rdata = 0; e_dm_rdata = 0;
      model_valid = 1;
    end else if (m_busy) begin
      e_if_ready = 0; e_dm_ready = 0;
      if (m_t == MEM_LAT + 1) begin
        m_busy = 0; m_t = 0;
      end else begin
        m_t++;
        if (m_t == MEM_LAT + 1) begin
          if (m_we) begin
            sh_mem[m_addr[9:0]] = m_wdata;
            sh_wr[m_addr[9:0]]  = 1;
          end else if (m_own) begin
            e_dm_rdata = sh_wr[m_addr[9:0]] ? sh_mem[m_addr[9:0]] : init_val(m_addr[9:0]);
          end else begin
            e_if_rdata = sh_wr[m_addr[9:0]] ? sh_mem[m_addr[9:0]] : init_val(m_addr[9:0]);
          end
          if (m_own) e_dm_ready = 1; else e_if_ready = 1;
        end
      end
    end else if (bus.if_req || bus.dm_req) begin
      take_fetch = bus.if_req && (!bus.dm_req || m_streak == DATA_MAX);
      if (take_fetch) begin
        m_own = 0; m_we = 0; m_addr = bus.if_addr; m_streak = 0;
      end else begin
        m_own = 1; m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
        m_streak = bus.if_req ? ((m_streak < DATA_MAX) ? m_streak + 1 : DATA_MAX) : 0;
      end
      m_busy = 1; m_t = 1;
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  bit exp_en;
  always @(negedge clk) begin
    if (model_valid) begin
      exp_en = m_busy && (m_t <= MEM_LAT);
      chk("mem_en", bus.mem_en, exp_en);
      chk("mem_we", bus.mem_we, exp_en && m_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      if (exp_en && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("if_ready", bus.if_ready, e_if_ready);
      chk("dm_ready", bus.dm_ready, e_dm_ready);
      chk("if_rdata", bus.if_rdata, e_if_rdata);
      chk("dm_rdata", bus.dm_rdata, e_dm_rdata);
      chk("stall_fetch", bus.stall_fetch, bus.if_req && !e_if_ready);
      chk("stall_pipe", bus.stall_pipe, bus.dm_req && !e_dm_ready);
      chk("ready_excl", bus.if_ready & bus.dm_ready, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_dm();
    bus.dm_req   = 1'b1;
    bus.dm_we    = ($urandom_range(0, 2) == 0);
    bus.dm_addr  = 16'($urandom_range(0, 63));
    bus.dm_wdata = 16'($urandom);
  endtask

  task automatic scramble_dm();
    bus.dm_we    = $urandom_range(0, 1) == 1;
    bus.dm_addr  = 16'($urandom_range(0, 63));
    bus.dm_wdata = 16'($urandom);
  endtask

  // Random requesters, reacting to the completions the model says must happen.
  task automatic auto_drive();
    if (bus.if_req) begin
      if (e_if_ready) begin
        bus.if_req  = ($urandom_range(0, 1) == 0);
        bus.if_addr = 16'($urandom_range(0, 63));
      end else if ($urandom_range(0, 15) == 0) begin
        bus.if_req = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      bus.if_req  = 1'b1;
      bus.if_addr = 16'($urandom_range(0, 63));
    end
    if (bus.dm_req) begin
      if (e_dm_ready) begin
        if ($urandom_range(0, 1) == 0) new_dm(); else bus.dm_req = 1'b0;
      end else if (m_busy && m_own && m_t <= MEM_LAT) begin
        if ($urandom_range(0, 3) == 0) scramble_dm();
        if ($urandom_range(0, 15) == 0) bus.dm_req = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.dm_req = 1'b0;
      end
    end else begin
      scramble_dm();
      if ($urandom_range(0, 2) == 0) new_dm();
    end
  endtask

  bit prev_en;
  bit grants [6];
  int n_g;

  initial begin
    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 16'h0000;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 16'h0000; bus.dm_wdata = 16'h0000;
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_if_ready", bus.if_ready, 1'b0);
    chk("rst_dm_rdata", bus.dm_rdata, 16'h0000);

    // Single fetch of 0x0010
    tick(); reset = 1'b1; bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      if (c == 3) bus.if_req = 1'b0;
      @(negedge clk);
      chk("t1_mem_en", bus.mem_en, (c == 1 || c == 2));
      if (c == 1 || c == 2) chk("t1_mem_addr", bus.mem_addr, 16'h0010);
      chk("t1_if_ready", bus.if_ready, c == 3);
      chk("t1_stall_fetch", bus.stall_fetch, c < 3);
      if (c == 3) chk("t1_if_rdata", bus.if_rdata, 16'hA5A5);
    end

    // Simultaneous fetch and data read: data first
    tick(); bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0200;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      if (c == 3) bus.dm_req = 1'b0;
      if (c == 7) bus.if_req = 1'b0;
      @(negedge clk);
      chk("t2_dm_ready", bus.dm_ready, c == 3);
      chk("t2_if_ready", bus.if_ready, c == 7);
      if (c == 3) chk("t2_dm_rdata", bus.dm_rdata, 16'h0F0F);
      if (c == 5) chk("t2_fetch_addr", bus.mem_addr, 16'h0020);
      if (c == 5) chk("t2_fetch_en", bus.mem_en, 1'b1);
    end

    // Data write, then read it back
    tick(); bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0300; bus.dm_wdata = 16'h1234;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      if (c == 3) bus.dm_req = 1'b0;
      @(negedge clk);
      chk("t3_mem_we", bus.mem_we, (c == 1 || c == 2));
      if (c == 1 || c == 2) chk("t3_mem_wdata", bus.mem_wdata, 16'h1234);
      chk("t3_dm_ready", bus.dm_ready, c == 3);
      if (c == 3) chk("t3_dm_rdata_held", bus.dm_rdata, 16'h0F0F);
    end
    tick(); bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0300;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      if (c == 3) bus.dm_req = 1'b0;
      @(negedge clk);
      if (c == 3) chk("t3_readback", bus.dm_rdata, 16'h1234);
    end

    // Both held: fetch forced through after DATA_MAX data grants
    tick(); bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0080;
    prev_en = 1'b0; n_g = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (bus.mem_en && !prev_en && n_g < 6) begin
        grants[n_g] = (bus.mem_addr == 16'h0040);
        n_g++;
      end
      prev_en = bus.mem_en;
    end
    chk("t4_grant_count", n_g, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_grant%0d_is_fetch", i), grants[i], i == 4);
    tick(); bus.if_req = 1'b0; bus.dm_req = 1'b0;
    for (int c = 0; c < 6; c++) tick();

    // Reset during the second access cycle, request held through it
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0200;
    tick(); tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    @(negedge clk);
    chk("t5_mem_en", bus.mem_en, 1'b0);
    chk("t5_dm_ready", bus.dm_ready, 1'b0);
    chk("t5_dm_rdata", bus.dm_rdata, 16'h0000);
    chk("t5_if_rdata", bus.if_rdata, 16'h0000);
    chk("t5_mem_addr", bus.mem_addr, 16'h0000);
    for (int c = 4; c <= 6; c++) begin
      tick();
      if (c == 6) bus.dm_req = 1'b0;
      @(negedge clk);
      chk("t5_regrant_en", bus.mem_en, c < 6);
      chk("t5_regrant_ready", bus.dm_ready, c == 6);
      if (c == 6) chk("t5_regrant_rdata", bus.dm_rdata, 16'h0F0F);
    end

    // Quiet bus
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      chk("t6_mem_en", bus.mem_en, 1'b0);
      chk("t6_ready", {bus.if_ready, bus.dm_ready}, 2'b00);
      chk("t6_stall", {bus.stall_fetch, bus.stall_pipe}, 2'b00);
    end

    // Random traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = ($urandom_range(0, 299) != 0);
      auto_drive();
    end
    tick(); reset = 1'b1; bus.if_req = 1'b0; bus.dm_req = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
